// File: rtl/vram_pixel_writer.sv
// Planar VRAM pixel writer: read-modify-write of one pixel bit in each enabled
// bit-plane (0x8000/0xA000/0xC000/0xE000), touching memory only on granted cycles.
module vram_pixel_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [3:0]  cmd_color,
    input  logic [3:0]  cmd_mask,
    input  logic        mem_grant,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0] state;
    logic [1:0] plane;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [3:0] color_q;
    logic [3:0] mask_q;
    logic [7:0] wbyte;
    logic       done_q;

    logic [3:0]  plane_en;
    logic [3:0]  plane_color;
    logic [7:0]  bitmask;
    logic [15:0] addr;
    logic        has_next;
    logic [1:0]  next_plane;
    logic [1:0]  first_plane;

    // Command bit 3 belongs to plane 0, so reverse into plane-indexed vectors.
    assign plane_en    = {mask_q[0], mask_q[1], mask_q[2], mask_q[3]};
    assign plane_color = {color_q[0], color_q[1], color_q[2], color_q[3]};
    assign bitmask     = 8'h80 >> x_q[2:0];

    // Base + byte column in bits 12:8 + (255 - y), which is simply ~y.
    assign addr = {1'b1, plane, x_q[7:3], ~y_q};

    always_comb begin
        if (cmd_mask[3])      first_plane = 2'd0;
        else if (cmd_mask[2]) first_plane = 2'd1;
        else if (cmd_mask[1]) first_plane = 2'd2;
        else                  first_plane = 2'd3;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        has_next   = 1'b0;
        next_plane = plane;
        for (int q = 3; q >= 1; q--) begin
            if (2'(q) > plane && plane_en[q]) begin
                has_next   = 1'b1;
                next_plane = 2'(q);
            end
        end
    end

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign mem_rd    = (state == S_RD) && !reset;
    assign mem_wr    = (state == S_WR) && !reset;
    assign mem_addr  = (mem_rd || mem_wr) ? addr : 16'h0000;
    assign mem_wdata = mem_wr ? wbyte : 8'h00;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            plane   <= 2'd0;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            color_q <= 4'h0;
            mask_q  <= 4'h0;
            wbyte   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        color_q <= cmd_color;
                        mask_q  <= cmd_mask;
                        if (cmd_mask == 4'h0) begin
                            done_q <= 1'b1;
                        end else begin
                            plane <= first_plane;
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_grant) state <= S_CAP;
                end
                S_CAP: begin
                    wbyte <= plane_color[plane] ? (mem_rdata | bitmask)
                                                : (mem_rdata & ~bitmask);
                    state <= S_WR;
                end
                S_WR: begin
                    if (mem_grant) begin
                        if (has_next) begin
                            plane <= next_plane;
                            state <= S_RD;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench for vram_pixel_writer: bus-level RAM model plus a
// pixel-level reference that predicts every plane write and the done timing.
module tb_vram_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_color;
    logic [3:0]  cmd_mask;
    logic        mem_grant;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    vram_pixel_writer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_mask(cmd_mask),
        .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0] ram    [0:65535];
    logic [7:0] refram [0:65535];
    wr_t act_q[$];
    wr_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        prev_stall = 1'b0;
    logic [25:0] prev_bus   = '0;

    // Bus-side RAM and protocol monitor.
    always @(posedge clk) begin
        if (mem_rd && mem_grant) mem_rdata <= ram[mem_addr];
        if (mem_wr && mem_grant) begin
            ram[mem_addr] <= mem_wdata;
            act_q.push_back('{addr: mem_addr, data: mem_wdata});
        end
        if (!reset) begin
            n_checks++;
            if ((!(mem_rd && mem_wr) && ((mem_rd || mem_wr) ||
                 (mem_addr == 16'h0 && mem_wdata == 8'h0))) !== 1'b1)
                $display("FAIL bus_idle_excl: rd=%b wr=%b addr=%h wdata=%h required exclusive rd/wr and zero addr/wdata when idle",
                         mem_rd, mem_wr, mem_addr, mem_wdata);
            else n_pass++;
            if (prev_stall) begin
                n_checks++;
                if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== prev_bus)
                    $display("FAIL stall_stable: bus=%h required %h", {mem_rd, mem_wr, mem_addr, mem_wdata}, prev_bus);
                else n_pass++;
            end
        end
        prev_stall <= (mem_rd || mem_wr) && !mem_grant && !reset;
        prev_bus   <= {mem_rd, mem_wr, mem_addr, mem_wdata};
    end

    function automatic logic grant_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 8) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic int plane_count(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    function automatic logic [15:0] pix_addr(input int p, input logic [7:0] x, input logic [7:0] y);
        return 16'(32'h8000 + p * 32'h2000 + (int'(x) / 8) * 256 + (255 - int'(y)));
    endfunction

    task automatic fill(input int mode, input logic [7:0] v);
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] b;
            b = (mode == 0) ? v : 8'($urandom);
            ram[i]    = b;
            refram[i] = b;
        end
    endtask

    // Predict the writes for a command, then offer it in the current cycle.
    task automatic start_cmd(input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] c, input logic [3:0] m);
        exp_q.delete();
        act_q.delete();
        for (int p = 0; p < 4; p++) begin
            if (m[3-p]) begin
                logic [15:0] a;
                logic [7:0]  bm, nw;
                a  = pix_addr(p, x, y);
                bm = 8'h80 >> (int'(x) % 8);
                nw = c[3-p] ? (refram[a] | bm) : (refram[a] & ~bm);
                refram[a] = nw;
                exp_q.push_back('{addr: a, data: nw});
            end
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_at_offer: got %b required 1", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1;
        cmd_x = x; cmd_y = y; cmd_color = c; cmd_mask = m;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x = 8'($urandom); cmd_y = 8'($urandom);
        cmd_color = 4'($urandom); cmd_mask = 4'($urandom);
    endtask

    // Cycle 1 is the first cycle after the acceptance edge.
    task automatic wait_done(input int mode, input int exp_cyc, input logic exp_busy);
        int cyc;
        cyc = 1;
        n_checks++;
        if (busy !== exp_busy) $display("FAIL busy_after_accept: got %b required %b", busy, exp_busy);
        else n_pass++;
        while (done !== 1'b1 && cyc < 400) begin
            mem_grant = grant_for(mode, cyc);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_timeout: no done within %0d cycles", cyc);
        else n_pass++;
        if (exp_cyc >= 0) begin
            n_checks++;
            if (cyc != exp_cyc) $display("FAIL done_cycle: got cycle %0d required %0d", cyc, exp_cyc);
            else n_pass++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL ready_with_done: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        else n_pass++;
        n_checks++;
        if (act_q.size() != exp_q.size())
            $display("FAIL write_count: got %0d required %0d", act_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== exp_q[i] || ram[exp_q[i].addr] !== exp_q[i].data)
                $display("FAIL write_%0d: got %h=%h required %h=%h", i,
                         act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_mask = 4'hF; cmd_color = 4'hF;
        cmd_x = 8'h00; cmd_y = 8'h00; mem_grant = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
                $display("FAIL reset_hold: ready=%b rd=%b wr=%b required 0/0/0", cmd_ready, mem_rd, mem_wr);
            else n_pass++;
        end
        reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0)
            $display("FAIL reset_release: ready=%b busy=%b done=%b addr=%h wdata=%h required 1/0/0/0000/00",
                     cmd_ready, busy, done, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_full_mask();
        fill(0, 8'h00);
        start_cmd(8'd0, 8'd0, 4'hF, 4'hF);
        wait_done(0, 13, 1'b1);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got %b required 0", done);
        else n_pass++;
    endtask

    task automatic test_color_pattern();
        fill(0, 8'hFF);
        start_cmd(8'd13, 8'd2, 4'h5, 4'hF);
        wait_done(0, 13, 1'b1);
        fill(0, 8'hFF);
        start_cmd(8'd13, 8'd2, 4'h5, 4'hF);
        wait_done(1, -1, 1'b1);
    endtask

    task automatic test_partial_mask();
        fill(0, 8'h00);
        start_cmd(8'd255, 8'd255, 4'h2, 4'h2);
        wait_done(0, 4, 1'b1);
        start_cmd(8'd77, 8'd9, 4'hF, 4'h0);
        wait_done(0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill(1, 8'h00);
        mem_grant = 1'b1;
        start_cmd(8'd40, 8'd100, 4'hA, 4'hF);
        wait_done(0, 13, 1'b1);
        start_cmd(8'd41, 8'd101, 4'h6, 4'h6);
        wait_done(0, 7, 1'b1);
    endtask

    task automatic test_reset_abort();
        logic [7:0]  s2, s3;
        logic [15:0] a2, a3;
        logic        seen_done;
        fill(1, 8'h00);
        a2 = pix_addr(2, 8'd100, 8'd50);
        a3 = pix_addr(3, 8'd100, 8'd50);
        s2 = refram[a2];
        s3 = refram[a3];
        mem_grant = 1'b1;
        start_cmd(8'd100, 8'd50, 4'h9, 4'hF);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
            $display("FAIL abort_in_reset: ready=%b busy=%b rd=%b wr=%b required 0/0/0/0", cmd_ready, busy, mem_rd, mem_wr);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", cmd_ready);
        else n_pass++;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done !== 1'b0) $display("FAIL abort_no_done: done pulsed, required none");
        else n_pass++;
        refram[a2] = s2;
        refram[a3] = s3;
        n_checks++;
        if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1])
            $display("FAIL abort_writes: got %0d writes required planes 0 and 1 only", act_q.size());
        else n_pass++;
        n_checks++;
        if (ram[a2] !== s2 || ram[a3] !== s3)
            $display("FAIL abort_untouched: got %h %h required %h %h", ram[a2], ram[a3], s2, s3);
        else n_pass++;
    endtask

    task automatic test_random();
        fill(1, 8'h00);
        for (int n = 0; n < 25; n++) begin
            logic [3:0] m;
            int mode, exp_cyc;
            m = 4'($urandom);
            mode = $urandom_range(0, 2);
            exp_cyc = (mode != 0) ? -1 : (m == 4'h0 ? 1 : 3 * plane_count(m) + 1);
            mem_grant = 1'b1;
            start_cmd(8'($urandom), 8'($urandom), 4'($urandom), m);
            wait_done(mode, exp_cyc, m != 4'h0);
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_color_pattern();
        test_partial_mask();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
